// File: rtl/viterbi_traceback_if.sv
// viterbi_traceback_if: step input and decoded-bit output handshakes for the
// Viterbi survivor traceback block. Signal names follow the block's port names.
interface viterbi_traceback_if #(
    parameter int unsigned STATES_N = 64
) ();
    localparam int unsigned SW = $clog2(STATES_N);

    logic [STATES_N-1:0] dec_i;
    logic [SW-1:0]       best_state_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic                bit_o;
    logic                out_valid_o;
    logic                out_ready_i;

    // Producer/consumer side (ACS feeding steps, sink taking bits)
    modport master (
        output dec_i,
        output best_state_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  bit_o,
        input  out_valid_o
    );

    // Traceback block side
    modport slave (
        input  dec_i,
        input  best_state_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output bit_o,
        output out_valid_o
    );
endinterface

// File: rtl/viterbi_traceback.sv
// viterbi_traceback: sliding-window survivor-memory traceback for a K=7
// Viterbi decoder. Each accepted step (once the window is full) triggers one
// traceback of TBLEN-1 steps from the best state, emitting the input bit of
// the oldest stored step.
// Optional feature: define VITERBI_TB_FLUSH_EN to add a flush_i input that
// clears the window and abandons any traceback in progress.
module viterbi_traceback #(
    parameter int unsigned STATES_N = 64,
    parameter int unsigned TBLEN    = 60
) (
    input  logic               clk_i,
    input  logic               rst_ni,
`ifdef VITERBI_TB_FLUSH_EN
    input  logic               flush_i,
`endif
    viterbi_traceback_if.slave bus
);

    localparam int unsigned SW    = $clog2(STATES_N);
    localparam int unsigned PTR_W = (TBLEN > 1) ? $clog2(TBLEN) : 1;
    localparam int unsigned CNT_W = $clog2(TBLEN + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(TBLEN - 1);
    localparam logic [PTR_W-1:0] STEP_LAST = PTR_W'(TBLEN - 2);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(TBLEN);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACE = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]    fill_q,      fill_d;
    logic [PTR_W-1:0]    tcnt_q,      tcnt_d;
    logic [SW-1:0]       trace_q,     trace_d;
    logic                bit_q,       bit_d;
    logic                in_ready_q,  in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic                wr_en_c;
    logic [SW-1:0]       trace_step_c;

    // Survivor memory: one decision vector per trellis step, never reset
    logic [STATES_N-1:0] mem_q [TBLEN];

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.bit_o       = bit_q;

    // State and control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            tcnt_q      <= '0;
            trace_q     <= '0;
            bit_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            tcnt_q      <= tcnt_d;
            trace_q     <= trace_d;
            bit_q       <= bit_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Survivor memory write at the current write pointer
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= bus.dec_i;
        end
    end

    // Next-state, pointer and output logic
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        tcnt_d       = tcnt_q;
        trace_d      = trace_q;
        bit_d        = bit_q;
        wr_en_c      = 1'b0;
        // Predecessor of the current trace state: drop the top bit and shift
        // in the stored survivor decision for that state.
        trace_step_c = {trace_q[SW-2:0], mem_q[rd_ptr_q][trace_q]};

        unique case (state_q)
            ST_FILL: begin
                if (bus.in_valid_i && in_ready_q) begin
                    wr_en_c  = 1'b1;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + CNT_W'(1);
                    end
                    // Full window: start from the newest step just written
                    if (fill_d == FILL_FULL) begin
                        state_d  = ST_TRACE;
                        trace_d  = bus.best_state_i;
                        rd_ptr_d = wr_ptr_q;
                        tcnt_d   = '0;
                    end
                end
            end
            ST_TRACE: begin
                trace_d  = trace_step_c;
                rd_ptr_d = (rd_ptr_q == '0) ? PTR_LAST : rd_ptr_q - PTR_W'(1);
                tcnt_d   = tcnt_q + PTR_W'(1);
                // Last step lands on the oldest step's state; its MSB is that step's input bit
                if (tcnt_q == STEP_LAST) begin
                    state_d = ST_OUT;
                    bit_d   = trace_step_c[SW-1];
                end
            end
            ST_OUT: begin
                if (bus.out_ready_i) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

`ifdef VITERBI_TB_FLUSH_EN
        // Flush wins over any handshake in the same cycle
        if (flush_i) begin
            state_d  = ST_FILL;
            wr_ptr_d = '0;
            fill_d   = '0;
            wr_en_c  = 1'b0;
        end
`endif

        in_ready_d  = (state_d == ST_FILL);
        out_valid_d = (state_d == ST_OUT);
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: randomized bench with a window-level traceback model
// and per-cycle comparison of the handshake outputs.
`timescale 1ns/1ps
module tb_viterbi_traceback;

    localparam int NS  = 64;
    localparam int TBL = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef VITERBI_TB_FLUSH_EN
    logic flush = 1'b0;
`endif

    viterbi_traceback_if #(.STATES_N(NS)) bus ();

    viterbi_traceback #(.STATES_N(NS), .TBLEN(TBL)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
`ifdef VITERBI_TB_FLUSH_EN
        .flush_i(flush),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [NS-1:0] hdec_q[$];
    logic [5:0]    hbest_q[$];
    int            m_phase = 0;   // 0 accepting, 1 busy, 2 presenting a bit
    int            m_cnt   = 0;
    int            m_fill  = 0;
    logic          m_bit   = 1'b0;
    int            cyc     = 0;

    logic          obs_q[$];
    logic          seen_valid = 1'b0;
    int            rdy_mode   = 0;  // 0 hold low, 1 always high, 2 random
    int            last_acc   = 0;
    logic [5:0]    ps         = '0;
    logic          upath[$];
    bit            pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    // Window traceback: walk back from the newest best state through the
    // predecessor rule, return the MSB of the oldest step's state.
    function automatic logic ref_bit();
        int newest = hdec_q.size() - 1;
        int s = int'(hbest_q[newest]);
        for (int k = 0; k < TBL - 1; k++) begin
            s = ((s * 2) % NS) + int'(hdec_q[newest - k][s]);
        end
        return (s >= NS / 2);
    endfunction

    // Behavioural model, advanced on every rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_fill = 0; m_bit = 1'b0;
            hdec_q.delete(); hbest_q.delete();
        end
`ifdef VITERBI_TB_FLUSH_EN
        else if (flush) begin
            m_phase = 0; m_fill = 0;
            hdec_q.delete(); hbest_q.delete();
        end
`endif
        else begin
            case (m_phase)
                0: if (bus.in_valid_i) begin
                    hdec_q.push_back(bus.dec_i);
                    hbest_q.push_back(bus.best_state_i);
                    if (hdec_q.size() > TBL) begin
                        void'(hdec_q.pop_front());
                        void'(hbest_q.pop_front());
                    end
                    if (m_fill < TBL) m_fill++;
                    if (m_fill == TBL) begin
                        m_bit   = ref_bit();
                        m_phase = 1;
                        m_cnt   = TBL - 1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (bus.out_ready_i) m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("in_ready", int'(bus.in_ready_o), int'(m_phase == 0));
            check("out_valid", int'(bus.out_valid_o), int'(m_phase == 2));
            if (m_phase == 2) check("bit", int'(bus.bit_o), int'(m_bit));
            if (bus.out_valid_o) seen_valid = 1'b1;
            if (bus.out_valid_o && bus.out_ready_i) obs_q.push_back(bus.bit_o);
        end
    end

    // Consumer ready generator
    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready_i = 1'b1;
                2:       bus.out_ready_i = 1'($urandom_range(0, 1));
                default: bus.out_ready_i = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [NS-1:0] d, input logic [5:0] b);
        int guard = 0;
        @(negedge clk);
        bus.dec_i        = d;
        bus.best_state_i = b;
        bus.in_valid_i   = 1'b1;
        while (bus.in_ready_o !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            timeout_fail("send");
            bus.in_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b0;
            bus.dec_i      = {$urandom, $urandom};
            last_acc       = cyc;
        end
    endtask

    // One encoder step from state ps with input u; non-path decisions random or zero
    task automatic send_path(input logic u, input bit junk);
        logic [5:0]    nxt;
        logic [NS-1:0] d;
        nxt = {u, ps[5:1]};
        d = junk ? {$urandom, $urandom} : '0;
        d[nxt] = ps[0];
        ps = nxt;
        send(d, nxt);
    endtask

    task automatic wait_outs(input int n, input string tag);
        int guard = 0;
        while (obs_q.size() < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (obs_q.size() < n) timeout_fail(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        seen_valid = 1'b0;
    endtask

    initial begin
        int   g;
        int   c0;
        logic b0;
        bus.dec_i        = '0;
        bus.best_state_i = '0;
        bus.in_valid_i   = 1'b0;

        // Reset values
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready_o), 1);
        check("rst_out_valid", int'(bus.out_valid_o), 0);
        check("rst_bit", int'(bus.bit_o), 0);

        // 59 steps produce nothing; 60th starts a traceback of fixed latency
        for (int i = 0; i < TBL - 1; i++) send('0, 6'h00);
        repeat (3) @(negedge clk);
        check("no_valid_59", int'(seen_valid), 0);
        send('0, 6'h00);
        c0 = last_acc;
        @(negedge clk);
        check("ready_low_after_60", int'(bus.in_ready_o), 0);
        g = 0;
        while (bus.out_valid_o !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("latency", cyc - c0, TBL - 1);
        check("zeros_bit", int'(bus.bit_o), 0);

        // Back-pressure: outputs hold while the consumer stalls
        b0 = bus.bit_o;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", int'(bus.out_valid_o), 1);
            check("hold_bit", int'(bus.bit_o), int'(b0));
            check("hold_ready", int'(bus.in_ready_o), 0);
        end
        rdy_mode = 1;
        wait_outs(1, "zeros_out");
        // One more step slides the window and triggers another traceback
        send('1, 6'h3F);
        wait_outs(2, "slide_out");
        if (obs_q.size() >= 2) check("slide_bit", int'(obs_q[1]), 0);

        // All-ones window from state 3F decodes to 1
        do_reset();
        for (int i = 0; i < TBL; i++) send('1, 6'h3F);
        wait_outs(1, "ones_out");
        if (obs_q.size() >= 1) check("ones_bit", int'(obs_q[0]), 1);

        // Known encoder path 1,0,1,1,0,0 then zeros
        do_reset();
        ps = '0;
        for (int i = 0; i < TBL + 5; i++) send_path((i < 6) ? pat[i] : 1'b0, 1'b0);
        wait_outs(6, "path_out");
        for (int i = 0; i < 6 && i < obs_q.size(); i++) check("path_bit", int'(obs_q[i]), int'(pat[i]));

        // Reset during a traceback abandons it
        do_reset();
        for (int i = 0; i < TBL; i++) send({$urandom, $urandom}, 6'($urandom_range(0, 63)));
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (TBL + 10) @(negedge clk);
        check("reset_abandon", obs_q.size(), 0);

        // Random encoder stream of 130 steps, outputs are the encoder inputs
        do_reset();
        ps = '0;
        upath.delete();
        for (int i = 0; i < 130; i++) begin
            logic u;
            u = 1'($urandom_range(0, 1));
            upath.push_back(u);
            send_path(u, 1'b1);
        end
        wait_outs(71, "stream_out");
        repeat (10) @(negedge clk);
        check("stream_count", obs_q.size(), 71);
        for (int i = 0; i < 71 && i < obs_q.size(); i++) check("stream_bit", int'(obs_q[i]), int'(upath[i]));

        // Fully random decisions and random consumer back-pressure
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 90; i++) send({$urandom, $urandom}, 6'($urandom_range(0, 63)));
        rdy_mode = 1;
        repeat (TBL + 20) @(negedge clk);
        check("random_count", obs_q.size(), 90 - (TBL - 1));

`ifdef VITERBI_TB_FLUSH_EN
        // Flush mid-traceback: no output, window restarts from empty
        do_reset();
        for (int i = 0; i < TBL; i++) send({$urandom, $urandom}, 6'($urandom_range(0, 63)));
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < TBL - 1; i++) send({$urandom, $urandom}, 6'($urandom_range(0, 63)));
        repeat (TBL + 10) @(negedge clk);
        check("flush_no_out", obs_q.size(), 0);
        send({$urandom, $urandom}, 6'($urandom_range(0, 63)));
        wait_outs(1, "flush_refill");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 SHALL have parameter STATES_N, default 64, number of trellis states (2**(K-1), K=7).
REQ-002 SHALL have parameter TBLEN, default 60, traceback depth in trellis steps.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port dec_i, input, STATES_N, survivor decisions from ACS; bit s = decision of state s.
REQ-006 SHALL have port best_state_i, input, 6, index of minimum-path-metric state for the same step.
REQ-007 SHALL have port in_valid_i, input, 1, dec_i/best_state_i valid.
REQ-008 SHALL have port in_ready_o, output, 1, block accepts a step this cycle.
REQ-009 SHALL have port bit_o, output, 1, decoded bit.
REQ-010 SHALL have port out_valid_o, output, 1, bit_o valid.
REQ-011 SHALL have port out_ready_i, input, 1, consumer accepts bit_o.

Function
REQ-012 SHALL use state convention next = {u, s[5:1]}; predecessor of s = {s[4:0], dec[s]}; input bit of state s = s[5].
REQ-013 SHALL store accepted steps in a TBLEN x STATES_N circular buffer at wr_ptr, wr_ptr incrementing and wrapping TBLEN-1 -> 0.
REQ-014 SHALL implement FSM FILL, TRACE, OUT; in_ready_o = 1 only in FILL; out_valid_o = 1 only in OUT.
REQ-015 FILL: on in_valid_i & in_ready_o SHALL write buffer, latch best_state_i, increment fill count (saturating at TBLEN).
REQ-016 FILL: if fill count equals TBLEN after the write, SHALL enter TRACE with trace state = best_state_i and rd_ptr = written index; else remain FILL.
REQ-017 TRACE: each cycle SHALL set trace state = {state[4:0], buf[rd_ptr][state]} and decrement rd_ptr with wrap 0 -> TBLEN-1.
REQ-018 TRACE SHALL perform exactly TBLEN-1 steps, then enter OUT with bit_o = final trace state[5] (oldest stored step's input bit).
REQ-019 out_valid_o SHALL rise exactly TBLEN-1 clock edges after the accepting edge.
REQ-020 OUT: bit_o and out_valid_o SHALL hold stable until out_ready_i; on handshake SHALL return to FILL.
REQ-021 After the first window, each further accepted step SHALL trigger one traceback (sliding window), overwriting the oldest entry.
REQ-022 in_valid_i SHALL be ignored outside FILL; dec_i not accepted SHALL not modify the buffer.

Reset
REQ-023 On rst_ni low: FSM = FILL, wr_ptr = 0, fill count = 0, rd_ptr = 0, trace state = 0.
REQ-024 Reset outputs: in_ready_o = 1, out_valid_o = 0, bit_o = 0; buffer contents not reset.
REQ-025 Reset asserted mid-TRACE or mid-OUT SHALL abandon the traceback with no output produced.

Configuration
REQ-026 Macro VITERBI_TB_FLUSH_EN defined: SHALL add input flush_i (1 bit); flush_i high in any state SHALL next cycle force FILL, wr_ptr = 0, fill count = 0, out_valid_o = 0, taking priority over a simultaneous input or output handshake.
REQ-027 Macro VITERBI_TB_FLUSH_EN undefined: flush_i port SHALL not exist; window cleared only by reset.

Verification
REQ-028 Reset released -> in_ready_o = 1, out_valid_o = 0, bit_o = 0.
REQ-029 Feed 59 steps -> out_valid_o never asserts; 60th accepted -> in_ready_o = 0 next cycle, out_valid_o = 1 exactly 59 edges later.
REQ-030 60 steps dec_i = all zeros, best_state_i = 0 -> bit_o = 0; dec_i = all ones, best_state_i = 6'h3F -> bit_o = 1.
REQ-031 Decisions built from known path encoding 1,0,1,1,0,0 then zeros -> first six outputs 1,0,1,1,0,0.
REQ-032 Hold out_ready_i = 0 for 5 cycles in OUT -> bit_o, out_valid_o stable, in_ready_o = 0; after handshake one new step -> new traceback.
REQ-033 Stream 130 steps with out_ready_i = 1 -> wr_ptr wraps twice, exactly 71 outputs; with VITERBI_TB_FLUSH_EN, flush_i mid-TRACE -> no output, next 59 steps produce none.
